sd_row_feeder: RTL

SD_ROW_FEEDER -- requirements
Module: sd_row_feeder

---
 rtl/sd_row_feeder_pkg.sv | 18 +
 rtl/sd_row_feeder_scan.sv | 25 ++
 rtl/sd_row_feeder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sd_row_feeder_pkg.sv
// Shared definitions for the sudoku row feeder.
// Holds the FSM state encoding, the grid geometry constants and the first
// digit value that is not a legal sudoku token.
package sd_row_feeder_pkg;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      CHECK  = 2'd1,
      STREAM = 2'd2,
      WAIT   = 2'd3
   } state_t;

   localparam int GRID_N = 9;
   localparam int CELLS  = 81;

   localparam logic [3:0] ILLEGAL_TOKEN = 4'd10;

endpackage

// File: rtl/sd_row_feeder_scan.sv
// sd_row_scan: combinational inspection of one 36-bit puzzle row.
// Ports:
//   row       - nine 4-bit cells, column c in bits [4c+3:4c]
//   zero_cnt  - number of blank (0) cells in the row, 0..9
//   bad_digit - 1 when any cell holds a value above 9
module sd_row_scan
   import sd_row_feeder_pkg::*;
(
   input  logic [35:0] row,
   output logic [3:0]  zero_cnt,
   output logic        bad_digit
);

   always_comb begin
      zero_cnt  = '0;
      bad_digit = 1'b0;
      for (int c = 0; c < GRID_N; c++) begin
         if (row[c*4 +: 4] == 4'd0)
            zero_cnt = zero_cnt + 4'd1;
         if (row[c*4 +: 4] >= ILLEGAL_TOKEN)
            bad_digit = 1'b1;
      end
   end

endmodule

// File: rtl/sd_row_feeder.sv
// sd_row_feeder: collects nine puzzle rows, sanity-checks the puzzle and
// streams its 81 cells in row-major order to a sudoku solver, then waits
// for the solver's answer stream to finish before accepting a new puzzle.
// Ports:
//   clk, rst_n    - clock and asynchronous active-low reset
//   row_valid     - upstream row word valid
//   row_ready     - row accepted this cycle (only while loading)
//   row_data      - one puzzle row, column c in bits [4c+3:4c], 0 = blank
//   sd_in_valid   - cell stream valid to the solver
//   sd_in         - cell value to the solver, 0 when not valid
//   sd_out_valid  - solver answer stream valid
//   err           - one-cycle pulse when a puzzle is rejected
//   busy          - high whenever not loading rows
module sd_row_feeder
   import sd_row_feeder_pkg::*;
#(
   parameter int MAX_BLANK = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        row_valid,
   output logic        row_ready,
   input  logic [35:0] row_data,
   output logic        sd_in_valid,
   output logic [3:0]  sd_in,
   input  logic        sd_out_valid,
   output logic        err,
   output logic        busy
);

   localparam logic [3:0] LAST_ROW    = 4'(GRID_N - 1);
   localparam logic [6:0] LAST_CELL   = 7'(CELLS - 1);
   localparam logic [6:0] BLANK_LIMIT = 7'(MAX_BLANK);

   state_t      state, next_state;
   logic [3:0]  row_cnt;
   logic [6:0]  blank_cnt;
   logic        bad_flag;
   logic [6:0]  cell_cnt;
   logic [35:0] grid [GRID_N];
   logic        sd_out_prev;

   logic [3:0]  row_zeros;
   logic        row_bad;
   logic        row_accept;
   logic        reject;
   logic [GRID_N*36-1:0] grid_flat;

   sd_row_scan u_scan (
      .row       (row_data),
      .zero_cnt  (row_zeros),
      .bad_digit (row_bad)
   );

   assign row_accept = row_valid && row_ready;
   assign reject     = bad_flag || (blank_cnt == 7'd0) || (blank_cnt > BLANK_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= LOAD;
      else
         state <= next_state;
   end

   always_comb begin
      next_state  = state;
      row_ready   = 1'b0;
      sd_in_valid = 1'b0;
      busy        = 1'b1;
      case (state)
         LOAD: begin
            row_ready = 1'b1;
            busy      = 1'b0;
            if (row_accept && row_cnt == LAST_ROW)
               next_state = CHECK;
         end
         CHECK: begin
            next_state = reject ? LOAD : STREAM;
         end
         STREAM: begin
            sd_in_valid = 1'b1;
            if (cell_cnt == LAST_CELL)
               next_state = WAIT;
         end
         WAIT: begin
            // Leave only on a sampled falling edge of the answer stream.
            if (sd_out_prev && !sd_out_valid)
               next_state = LOAD;
         end
         default: next_state = LOAD;
      endcase
   end

   // Rows are packed so that cell k (row-major) sits at bits [4k+3:4k],
   // since row r col c lives at 36r + 4c = 4(9r + c).
   always_comb begin
      grid_flat = '0;
      for (int r = 0; r < GRID_N; r++)
         grid_flat[r*36 +: 36] = grid[r];
   end

   assign sd_in = sd_in_valid ? grid_flat[{cell_cnt, 2'b00} +: 4] : 4'd0;

   // Row capture, blank counting and stream position. Counters are cleared
   // on leaving CHECK whichever way the puzzle goes; the grid is kept so it
   // can be streamed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt     <= '0;
         blank_cnt   <= '0;
         bad_flag    <= 1'b0;
         cell_cnt    <= '0;
         err         <= 1'b0;
         sd_out_prev <= 1'b0;
         for (int r = 0; r < GRID_N; r++)
            grid[r] <= '0;
      end else begin
         err         <= 1'b0;
         sd_out_prev <= (state == WAIT) && sd_out_valid;
         case (state)
            LOAD: begin
               if (row_accept) begin
                  grid[row_cnt] <= row_data;
                  blank_cnt     <= blank_cnt + {3'b000, row_zeros};
                  bad_flag      <= bad_flag | row_bad;
                  row_cnt       <= (row_cnt == LAST_ROW) ? 4'd0 : row_cnt + 4'd1;
               end
            end
            CHECK: begin
               err       <= reject;
               row_cnt   <= '0;
               blank_cnt <= '0;
               bad_flag  <= 1'b0;
            end
            STREAM: begin
               cell_cnt <= (cell_cnt == LAST_CELL) ? 7'd0 : cell_cnt + 7'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
